pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement add/subtract unit. Splits an `xlen`-bit operation into `stages` equal chunks and resolves one chunk per cycle, with carry passed between pipeline registers. Throughput is one operation per cycle with a valid/ready handshake on both sides. It is the multi-cycle successor to the combinational ripple-carry adder in the mini-CPU datapath and serves as the ALU adder once `xlen` grows beyond single-cycle timing.

---
 rtl/pipelined_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract: xlen bits split into stages chunks,
// one chunk resolved per cycle, carry handed forward through stage registers.
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   in_valid/in_ready   - operand handshake (a, b, carry_in, sub)
//   out_valid/out_ready - result handshake (sum, carry_out, overflow, zero)
//   sub=1 computes a-b (carry_in ignored), sub=0 computes a+b+carry_in.
//   stages must be >= 1 and divide xlen.
module pipelined_adder #(
  parameter int xlen   = 32,
  parameter int stages = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [xlen-1:0] sum,
  output logic            carry_out,
  output logic            overflow,
  output logic            zero
);

  localparam int w = xlen / stages;

  logic              stall;
  logic              adv;
  logic              accept;
  logic [stages-1:0] v;
  logic [xlen-1:0]   b_eff;
  logic              c_eff;
  logic [xlen-1:0]   sum_d;
  logic              zero_d;
  logic              ovf_d;
  logic              top_co;
  logic              top_a;
  logic              top_b;
  logic [w-1:0]      res [stages];

  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = v[stages-1];

  // Subtract as a + ~b + 1.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | carry_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (adv) begin
      v[0] <= accept;
      for (int k = 1; k < stages; k++) begin
        v[k] <= v[k-1];
      end
    end
  end

  for (genvar k = 0; k < stages; k++) begin : g_chunk
    logic [w-1:0] op_a;
    logic [w-1:0] op_b;
    logic         cin;
    logic [w:0]   s;

    if (k == 0) begin : g_in
      assign op_a = a[w-1:0];
      assign op_b = b_eff[w-1:0];
      assign cin  = c_eff;
    end else begin : g_skew
      // Chunk k waits k cycles so it meets the carry from chunk k-1.
      logic [w-1:0] sa [k];
      logic [w-1:0] sb [k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            sa[j] <= '0;
            sb[j] <= '0;
          end
        end else if (adv) begin
          sa[0] <= a[k*w +: w];
          sb[0] <= b_eff[k*w +: w];
          for (int j = 1; j < k; j++) begin
            sa[j] <= sa[j-1];
            sb[j] <= sb[j-1];
          end
        end
      end

      assign op_a = sa[k-1];
      assign op_b = sb[k-1];
      assign cin  = g_chunk[k-1].g_mid.cq;
    end

    assign s = {1'b0, op_a} + {1'b0, op_b} + {{w{1'b0}}, cin};

    if (k < stages - 1) begin : g_mid
      // Lower chunks are delayed until the top chunk catches up.
      localparam int d = stages - 1 - k;
      logic         cq;
      logic [w-1:0] dq [d];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cq <= 1'b0;
          for (int j = 0; j < d; j++) begin
            dq[j] <= '0;
          end
        end else if (adv) begin
          cq    <= s[w];
          dq[0] <= s[w-1:0];
          for (int j = 1; j < d; j++) begin
            dq[j] <= dq[j-1];
          end
        end
      end

      assign res[k] = dq[d-1];
    end else begin : g_top
      // Top chunk also carries the operand sign bits for overflow.
      assign res[k] = s[w-1:0];
      assign top_co = s[w];
      assign top_a  = op_a[w-1];
      assign top_b  = op_b[w-1];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < stages; k++) begin
      sum_d[k*w +: w] = res[k];
    end
  end

  assign zero_d = ~|sum_d;
  assign ovf_d  = (top_a == top_b) & (sum_d[xlen-1] != top_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      sum       <= sum_d;
      carry_out <= top_co;
      overflow  <= ovf_d;
      zero      <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on an 8/4 unit plus
// randomized runs over several xlen/stages configurations.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Directed unit, xlen=8, stages=4
  logic       m_rst = 1'b1;
  logic       m_iv = 1'b0;
  logic       m_ir;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic       m_ci = 1'b0;
  logic       m_sub = 1'b0;
  logic       m_ov;
  logic       m_ordy = 1'b1;
  logic [7:0] m_sum;
  logic       m_co;
  logic       m_of;
  logic       m_z;

  pipelined_adder #(.xlen(8), .stages(4)) u_dut (
    .clk(clk), .rst(m_rst),
    .in_valid(m_iv), .in_ready(m_ir),
    .a(m_a), .b(m_b), .carry_in(m_ci), .sub(m_sub),
    .out_valid(m_ov), .out_ready(m_ordy),
    .sum(m_sum), .carry_out(m_co), .overflow(m_of), .zero(m_z)
  );

  // exp = {carry_out, overflow, zero, sum}
  task automatic op1(input string tag, input logic [7:0] x,
                     input logic [7:0] y, input logic s, input logic c,
                     input logic [10:0] exp);
    int n;
    @(negedge clk);
    m_a = x; m_b = y; m_sub = s; m_ci = c;
    m_iv = 1'b1; m_ordy = 1'b1;
    #1;
    check({tag, "_rdy"}, 64'(m_ir), 64'(1));
    @(negedge clk);
    m_iv = 1'b0;
    n = 1;
    while (!m_ov && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(4));
    check(tag, 64'({m_co, m_of, m_z, m_sum}), 64'(exp));
  endtask

  task automatic b2b();
    int sent = 0;
    int got = 0;
    int sl = -1;
    int cyc = 0;
    logic [7:0] held = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m_ov && sl < 0) sl = 3;
      m_ordy = !(sl > 0);
      m_iv = (sent < 8);
      m_a = 8'(sent); m_b = 8'h10; m_sub = 1'b0; m_ci = 1'b0;
      #1;
      if (sl > 0) begin
        check("stall_rdy", 64'(m_ir), 64'(0));
        if (sl < 3) check("stall_hold", 64'(m_sum), 64'(held));
        held = m_sum;
        sl--;
      end
      if (m_ov && m_ordy) begin
        check("b2b", 64'(m_sum), 64'(8'h10 + got));
        got++;
      end
      if (m_iv && m_ir) sent++;
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    check("b2b_cnt", 64'(got), 64'(8));
  endtask

  task automatic rst_flight();
    int seen = 0;
    @(negedge clk);
    m_ordy = 1'b1; m_iv = 1'b1; m_sub = 1'b0; m_ci = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_a = 8'(k + 1); m_b = 8'h20;
      @(negedge clk);
    end
    m_iv = 1'b0;
    m_rst = 1'b1;
    #1;
    check("rst_async_ov", 64'(m_ov), 64'(0));
    check("rst_async_sum", 64'(m_sum), 64'(0));
    @(negedge clk);
    m_rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_ov) seen++;
    end
    check("rst_stale", 64'(seen), 64'(0));
  endtask

  // Randomized configurations
  logic rst_s = 1'b1;

  for (genvar i = 0; i < 5; i++) begin : g_sw
    localparam int XL = (i == 3) ? 32 : 8;
    localparam int ST = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 4;
    localparam longint HALF = longint'(1) <<< (XL - 1);

    logic          iv = 1'b0;
    logic          ir;
    logic          ov;
    logic          ordy = 1'b1;
    logic          sb = 1'b0;
    logic          ci = 1'b0;
    logic          co;
    logic          of;
    logic          z;
    logic [XL-1:0] a = '0;
    logic [XL-1:0] b = '0;
    logic [XL-1:0] s;
    int            cyc = 0;

    pipelined_adder #(.xlen(XL), .stages(ST)) u_sw (
      .clk(clk), .rst(rst_s),
      .in_valid(iv), .in_ready(ir),
      .a(a), .b(b), .carry_in(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .sum(s), .carry_out(co), .overflow(of), .zero(z)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Plain integer arithmetic: unsigned for sum/carry, signed for overflow.
    function automatic logic [63:0] model(input logic [XL-1:0] x,
                                          input logic [XL-1:0] y,
                                          input logic sub_op,
                                          input logic cin);
      longint ux, uy, sx, sy, ru, rs;
      logic [XL-1:0] r;
      logic c_o, o_f;
      ux = longint'(x);
      uy = longint'(y);
      sx = x[XL-1] ? ux - 2 * HALF : ux;
      sy = y[XL-1] ? uy - 2 * HALF : uy;
      if (sub_op) begin
        ru = ux - uy;
        rs = sx - sy;
        c_o = (ux >= uy);
      end else begin
        ru = ux + uy + longint'(cin);
        rs = sx + sy + longint'(cin);
        c_o = (ru >= 2 * HALF);
      end
      r = XL'(ru);
      o_f = (rs >= HALF) || (rs < -HALF);
      return 64'({c_o, o_f, (r == '0), r});
    endfunction

    initial begin : p_rand
      logic [63:0] q[$];
      int tq[$];
      int sq[$];
      int issued = 0;
      int nst = 0;
      bit seen = 1'b0;
      wait (!rst_s);
      for (int n = 0; n < 6000 && (issued < 1000 || q.size() > 0); n++) begin
        @(negedge clk);
        if (ov) begin
          if (q.size() == 0) begin
            check("sw_extra", 64'(ov), 64'(0));
          end else begin
            check("sw_res", 64'({co, of, z, s}), q[0]);
            if (!seen) begin
              check("sw_lat", 64'(cyc - tq[0] + 1), 64'(ST + nst - sq[0]));
              seen = 1'b1;
            end
          end
        end
        ordy = (issued < 300) ? 1'b1 : ($urandom_range(3) != 0);
        iv = (issued < 1000) && ($urandom_range(4) != 0);
        a = XL'($urandom());
        b = XL'($urandom());
        sb = 1'($urandom_range(1));
        ci = 1'($urandom_range(1));
        #1;
        check("sw_rdy", 64'(ir), 64'(!(ov && !ordy)));
        if (ov && !ordy) nst++;
        if (ov && ordy && q.size() > 0) begin
          void'(q.pop_front());
          void'(tq.pop_front());
          void'(sq.pop_front());
          seen = 1'b0;
        end
        if (iv && ir) begin
          q.push_back(model(a, b, sb, ci));
          tq.push_back(cyc + 1);
          sq.push_back(nst);
          issued++;
        end
      end
      iv = 1'b0;
      check("sw_drain", 64'(q.size()), 64'(0));
      check("sw_issued", 64'(issued), 64'(1000));
      n_done++;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    m_rst = 1'b0;
    rst_s = 1'b0;
    #1;
    check("rst_ov", 64'(m_ov), 64'(0));
    check("rst_rdy", 64'(m_ir), 64'(1));
    check("rst_sum", 64'(m_sum), 64'(0));
    check("rst_flags", 64'({m_co, m_of, m_z}), 64'(0));

    op1("add_co",  8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    op1("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80});
    op1("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 8'h7F});
    op1("sub_brw", 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE});
    op1("add_ci",  8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 8'h31});
    op1("sub_eq",  8'h5A, 8'h5A, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    b2b();
    rst_flight();
    op1("fresh",   8'h03, 8'h04, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 8'h07});

    for (int k = 0; k < 20000 && n_done < 5; k++) @(negedge clk);
    check("sweep_done", 64'(n_done), 64'(5));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
